register_bank_mux: RTL and testbench

Parametrised register bank with one write port, two synchronous read ports and a sequential dump engine. It replaces the fixed 16-entry, 32-bit combinational 16:1 select with a configurable bank. The bank supports write-to-read bypass, optional hardwired-zero register 0, and a valid/ready dump channel that streams every register in address order. It sits in the datapath between the instruction decoder (register addresses) and the ALU operand latches; the dump channel feeds the debug/trace unit.

---
 rtl/register_bank_pkg.sv | 6 +
 rtl/register_bank_read_port.sv | 29 ++
 rtl/register_bank_mux.sv | 76 +++++++
 tb/tb_register_bank_mux.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// register_bank_pkg: shared constants and dump state encoding for the register bank
package register_bank_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  typedef enum logic {DUMP_IDLE, DUMP_RUN} dump_state_t;
endpackage

// File: rtl/register_bank_read_port.sv
// register_bank_read_port: range-checked DEPTH:1 select with write-first bypass into a load-enabled register
module register_bank_read_port #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter bit R0_ZERO = 1'b0,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] regs [DEPTH],
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] data
);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
  logic in_range, zero_reg, wr_ok, hit;
  logic [WIDTH-1:0] nxt;
  assign in_range = {1'b0, addr} < LIM;
  assign zero_reg = R0_ZERO && addr == '0;
  assign wr_ok = we && ({1'b0, waddr} < LIM) && !(R0_ZERO && waddr == '0);
  assign hit = wr_ok && waddr == addr;
  assign nxt = (!in_range || zero_reg) ? '0 : hit ? wdata : regs[addr];
  always_ff @(posedge clk)
    if (reset) data <= '0;
    else if (load) data <= nxt;
endmodule

// File: rtl/register_bank_mux.sv
// register_bank_mux: parametrised register bank with two registered read ports and a valid/ready dump stream
module register_bank_mux
  import register_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter bit R0_ZERO = 1'b0,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_last
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] regs [DEPTH];
  logic wr_ok, start, advance, finish;
  logic [AW-1:0] ptr, beat_addr;
  dump_state_t state, state_nxt;
  assign wr_ok = we && ({1'b0, waddr} < LIM) && !(R0_ZERO && waddr == '0);
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  always_ff @(posedge clk) state <= reset ? DUMP_IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    start = 1'b0;
    advance = 1'b0;
    finish = 1'b0;
    if (state == DUMP_IDLE) begin
      start = dump_start;
      state_nxt = dump_start ? DUMP_RUN : DUMP_IDLE;
    end else if (dump_ready) begin
      advance = ptr != LAST;
      finish = ptr == LAST;
      state_nxt = (ptr == LAST) ? DUMP_IDLE : DUMP_RUN;
    end
  end
  // ptr parks at 0 between dumps so the next dump always begins at address 0
  always_ff @(posedge clk)
    if (reset || start || finish) ptr <= '0;
    else if (advance) ptr <= ptr + AW'(1);
  assign beat_addr = start ? '0 : ptr + AW'(1);
  assign dump_busy = state == DUMP_RUN;
  assign dump_valid = dump_busy;
  assign dump_addr = ptr;
  assign dump_last = dump_busy && ptr == LAST;
  register_bank_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO), .AW(AW)) u_port_a (
    .clk(clk), .reset(reset), .load(1'b1), .addr(raddr_a), .regs(regs),
    .we(we), .waddr(waddr), .wdata(wdata), .data(rdata_a)
  );
  register_bank_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO), .AW(AW)) u_port_b (
    .clk(clk), .reset(reset), .load(1'b1), .addr(raddr_b), .regs(regs),
    .we(we), .waddr(waddr), .wdata(wdata), .data(rdata_b)
  );
  register_bank_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO), .AW(AW)) u_beat (
    .clk(clk), .reset(reset), .load(start || advance), .addr(beat_addr), .regs(regs),
    .we(we), .waddr(waddr), .wdata(wdata), .data(dump_data)
  );
endmodule

// File: tb/tb_register_bank_mux.sv
// tb_register_bank_mux: scoreboard bench comparing two bank instances (R0_ZERO off/on) against a behavioural model
module tb_register_bank_mux;
  localparam int W = 32;
  localparam int D = 16;
  localparam int A = 4;
  typedef struct {string tag; int src; logic [W-1:0] val;} exp_t;
  logic clk = 1'b0, reset = 1'b1, we = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
  logic [A-1:0] waddr = '0, raddr_a = '0, raddr_b = '0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] rdata_a, rdata_b, dump_data, za, zb, zd;
  logic [A-1:0] dump_addr, zaddr;
  logic dump_busy, dump_valid, dump_last, zbusy, zvalid, zlast;
  logic [W-1:0] mem [D];
  logic [W-1:0] memz [D];
  bit mrun = 0;
  int mptr = 0;
  logic [W-1:0] mbeat = '0;
  exp_t sbq[$];
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  register_bank_mux #(.WIDTH(W), .DEPTH(D), .R0_ZERO(1'b0)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last)
  );
  register_bank_mux #(.WIDTH(W), .DEPTH(D), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(za), .raddr_b(raddr_b), .rdata_b(zb),
    .dump_start(1'b0), .dump_busy(zbusy), .dump_valid(zvalid), .dump_ready(1'b1),
    .dump_addr(zaddr), .dump_data(zd), .dump_last(zlast)
  );
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, want, $time);
    end
  endtask
  function automatic logic [W-1:0] observe(input int src);
    case (src)
      0: return rdata_a;
      1: return rdata_b;
      2: return za;
      3: return dump_data;
      4: return W'(dump_addr);
      5: return W'(dump_valid);
      6: return W'(dump_busy);
      default: return W'(dump_last);
    endcase
  endfunction
  function automatic void push(input string tag, input int src, input logic [W-1:0] val);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.val = val;
    sbq.push_back(e);
  endfunction
  task automatic step(input bit rd, input bit dmp);
    logic [W-1:0] ea, eb, ez;
    bit wv, wz;
    exp_t e;
    wv = we;
    wz = we && waddr != '0;
    ea = (wv && waddr == raddr_a) ? wdata : mem[raddr_a];
    eb = (wv && waddr == raddr_b) ? wdata : mem[raddr_b];
    ez = (raddr_a == '0) ? '0 : (wz && waddr == raddr_a) ? wdata : memz[raddr_a];
    if (!mrun) begin
      if (dump_start) begin
        mrun = 1;
        mptr = 0;
        mbeat = (wv && waddr == '0) ? wdata : mem[0];
      end
    end else if (dump_ready) begin
      if (mptr == D - 1) mrun = 0;
      else begin
        mptr++;
        mbeat = (wv && waddr == A'(mptr)) ? wdata : mem[mptr];
      end
    end
    if (wv) mem[waddr] = wdata;
    if (wz) memz[waddr] = wdata;
    if (reset) begin
      foreach (mem[i]) begin
        mem[i] = '0;
        memz[i] = '0;
      end
      mrun = 0;
      mptr = 0;
      mbeat = '0;
      ea = '0;
      eb = '0;
      ez = '0;
    end
    if (rd || reset) begin
      push("rdata_a", 0, ea);
      push("rdata_b", 1, eb);
      push("rdata_a_r0zero", 2, ez);
    end
    if (dmp || reset) begin
      push("dump_data", 3, mbeat);
      push("dump_valid", 5, W'(mrun));
      push("dump_busy", 6, W'(mrun));
      push("dump_last", 7, W'(mrun && mptr == D - 1));
      if (mrun || reset) push("dump_addr", 4, W'(mptr));
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, observe(e.src), e.val);
    end
  endtask
  initial begin
    foreach (mem[i]) begin
      mem[i] = '0;
      memz[i] = '0;
    end
    reset = 1'b1;
    dump_start = 1'b1;
    dump_ready = 1'b1;
    step(1, 1);
    step(1, 1);
    reset = 1'b0;
    dump_start = 1'b0;
    for (int i = 0; i < D; i++) begin
      raddr_a = A'(i);
      raddr_b = A'(D - 1 - i);
      step(1, 1);
    end
    for (int i = 0; i < D; i++) begin
      we = 1'b1;
      waddr = A'(i);
      wdata = W'(i * 10);
      step(0, 0);
    end
    we = 1'b0;
    for (int i = 0; i < D; i++) begin
      raddr_a = A'(i);
      raddr_b = A'(D - 1 - i);
      step(1, 0);
    end
    we = 1'b1;
    waddr = 4'd5;
    wdata = 32'hDEADBEEF;
    raddr_a = 4'd5;
    raddr_b = 4'd6;
    step(1, 0);
    we = 1'b0;
    step(1, 0);
    we = 1'b1;
    wdata = 32'd50;
    step(1, 0);
    waddr = 4'd0;
    wdata = 32'h1234;
    raddr_a = 4'd0;
    step(1, 0);
    we = 1'b0;
    step(1, 0);
    we = 1'b1;
    wdata = '0;
    step(1, 0);
    we = 1'b0;
    for (int k = 0; k < 100; k++) begin
      dump_ready = (k % 4 == 0) || (k % 4 == 3);
      dump_start = (k == 0) || (k == 21);
      step(0, 1);
      if (!mrun) break;
    end
    dump_start = 1'b0;
    dump_ready = 1'b1;
    step(0, 1);
    step(0, 1);
    dump_start = 1'b1;
    step(0, 1);
    dump_start = 1'b0;
    for (int k = 0; k < 20 && mptr != 7; k++) step(0, 1);
    reset = 1'b1;
    step(1, 1);
    reset = 1'b0;
    dump_ready = 1'b0;
    dump_start = 1'b1;
    step(0, 1);
    dump_start = 1'b0;
    dump_ready = 1'b1;
    repeat (3) step(0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
